// File: rtl/buscaminas_vga.sv
// buscaminas_vga: renders the minesweeper core's 8x8 board, cursor and game
// state as a 640x480@60Hz VGA image. Pixel rate is clk/2; two pipeline stages
// (cell fetch, then colour) sit between the raster counters and the outputs.
module buscaminas_vga #(
    parameter int unsigned X0      = 80,
    parameter logic [3:0]  ST_WIN  = 4'd6,
    parameter logic [3:0]  ST_LOSE = 4'd7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0][7:0][6:0]  tablero,
    input  logic [2:0]            i_actual,
    input  logic [2:0]            j_actual,
    input  logic [3:0]            state,
    output logic                  vga_clk,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank_n,
    output logic                  sync_n,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b
);

    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XR = 10'(X0 + 480);

    // raster and cell counters
    logic       pe;
    logic [9:0] hc, vc, hc_d, vc_d;
    logic [5:0] sx, sy, sx_d, sy_d;
    logic [2:0] cj, ri, cj_d, ri_d;
    logic       hc_wrap, vc_wrap;

    // stage 1
    logic       vis1, inb1, hs1, vs1, cur1, win1, lose1;
    logic [5:0] sx1, sy1;
    logic [6:0] cell1;

    // colour decode
    logic [23:0] rgb_d;
    logic        centre, border;

    assign vga_clk = pe;
    assign sync_n  = 1'b0;

    function automatic logic edge_band(input logic [5:0] v);
        return ((v >= 6'd1) && (v <= 6'd3)) || ((v >= 6'd56) && (v <= 6'd59));
    endfunction

    function automatic logic [23:0] palette(input logic [3:0] n);
        logic [23:0] c;
        case (n)
            4'd1:    c = 24'h0000FF;
            4'd2:    c = 24'h008000;
            4'd3:    c = 24'hFF0000;
            4'd4:    c = 24'h000080;
            4'd5:    c = 24'h800000;
            4'd6:    c = 24'h008080;
            4'd7:    c = 24'h000000;
            default: c = 24'h808080;
        endcase
        return c;
    endfunction

    // next-state of raster and cell sub-counters (no divider: sx/sy count cell pixels)
    always_comb begin
        hc_wrap = (hc == 10'd799);
        vc_wrap = (vc == 10'd524);
        hc_d    = hc_wrap ? 10'd0 : hc + 10'd1;
        vc_d    = vc;
        sx_d    = sx + 6'd1;
        cj_d    = cj;
        sy_d    = sy;
        ri_d    = ri;
        if (hc_d == XL) begin
            sx_d = 6'd0;
            cj_d = 3'd0;
        end else if (sx == 6'd59) begin
            sx_d = 6'd0;
            cj_d = (cj == 3'd7) ? 3'd7 : cj + 3'd1;   // saturate, never wrap into board
        end
        if (hc_wrap) begin
            vc_d = vc_wrap ? 10'd0 : vc + 10'd1;
            if (vc_wrap) begin
                sy_d = 6'd0;
                ri_d = 3'd0;
            end else if (sy == 6'd59) begin
                sy_d = 6'd0;
                ri_d = (ri == 3'd7) ? 3'd7 : ri + 3'd1;
            end else begin
                sy_d = sy + 6'd1;
            end
        end
    end

    // pixel-enable toggle and counter registers, advancing once per two clk
    always_ff @(posedge clk) begin
        if (!rst) begin
            pe <= 1'b0;
            hc <= '0;
            vc <= '0;
            sx <= '0;
            sy <= '0;
            cj <= '0;
            ri <= '0;
        end else begin
            pe <= ~pe;
            if (pe) begin
                hc <= hc_d;
                vc <= vc_d;
                sx <= sx_d;
                sy <= sy_d;
                cj <= cj_d;
                ri <= ri_d;
            end
        end
    end

    // stage 1: position flags and cell fetch for the current raster position
    always_ff @(posedge clk) begin
        if (!rst) begin
            vis1  <= 1'b0;
            inb1  <= 1'b0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            cur1  <= 1'b0;
            win1  <= 1'b0;
            lose1 <= 1'b0;
            sx1   <= '0;
            sy1   <= '0;
            cell1 <= '0;
        end else if (pe) begin
            vis1  <= (hc < 10'd640) && (vc < 10'd480);
            inb1  <= (hc >= XL) && (hc < XR) && (vc < 10'd480);
            hs1   <= !((hc >= 10'd656) && (hc <= 10'd751));
            vs1   <= !((vc >= 10'd490) && (vc <= 10'd491));
            cur1  <= (ri == i_actual) && (cj == j_actual);
            win1  <= (state == ST_WIN);
            lose1 <= (state == ST_LOSE);
            sx1   <= sx;
            sy1   <= sy;
            cell1 <= tablero[ri][cj];
        end
    end

    // colour priority for the pixel held in stage 1
    always_comb begin
        rgb_d  = 24'h000000;
        centre = (sx1 >= 6'd20) && (sx1 <= 6'd39) && (sy1 >= 6'd20) && (sy1 <= 6'd39);
        border = edge_band(sx1) || edge_band(sy1);
        if (!vis1) begin
            rgb_d = 24'h000000;
        end else if (!inb1) begin
            rgb_d = win1 ? 24'h008000 : 24'h000000;
        end else if ((sx1 == 6'd0) || (sy1 == 6'd0)) begin
            rgb_d = 24'h404040;
        end else if (cur1 && border) begin
            rgb_d = 24'hFFFF00;
        end else if (cell1[4] && (cell1[6] || lose1)) begin
            rgb_d = centre ? 24'h000000 : 24'hFF0000;
        end else if (!cell1[6]) begin
            rgb_d = (cell1[5] && centre) ? 24'hFF0000 : 24'h808080;
        end else if ((cell1[3:0] != 4'd0) && centre) begin
            rgb_d = palette(cell1[3:0]);
        end else begin
            rgb_d = 24'hC0C0C0;
        end
    end

    // stage 2: registered outputs, all aligned to the same pixel
    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else if (pe) begin
            hsync   <= hs1;
            vsync   <= vs1;
            blank_n <= vis1;
            r       <= rgb_d[23:16];
            g       <= rgb_d[15:8];
            b       <= rgb_d[7:0];
        end
    end

endmodule

// File: tb/tb_buscaminas_vga.sv
// Directed bench for buscaminas_vga: reset state, sync/blank timing and
// per-pixel colours located by counting pixel ticks from reset release.
module tb_buscaminas_vga;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [7:0][7:0][6:0] tablero;
    logic [2:0]           i_actual, j_actual;
    logic [3:0]           state;
    logic                 vga_clk, hsync, vsync, blank_n, sync_n;
    logic [7:0]           r, g, b;

    int total = 0;
    int bad   = 0;
    int cur_k = 0;
    int n, m;

    buscaminas_vga dut (
        .clk      (clk),
        .rst      (rst),
        .tablero  (tablero),
        .i_actual (i_actual),
        .j_actual (j_actual),
        .state    (state),
        .vga_clk  (vga_clk),
        .hsync    (hsync),
        .vsync    (vsync),
        .blank_n  (blank_n),
        .sync_n   (sync_n),
        .r        (r),
        .g        (g),
        .b        (b)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // release reset at a falling edge; pixel (0,0) shows at the 4th rising edge
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cur_k = 0;
    endtask

    // advance to the rising edge where pixel (x,y) is on the outputs, then sample
    task automatic goto_px(input int x, input int y);
        int k;
        k = y * 800 + x;
        if (k < cur_k) begin
            chk("goto_order", 32'(k), 32'(cur_k));
        end else begin
            repeat (2 * (k - cur_k)) @(posedge clk);
            #1;
            cur_k = k;
        end
    endtask

    task automatic chk_px(input string tag, input int x, input int y, input logic [23:0] exp);
        goto_px(x, y);
        chk(tag, {8'h0, r, g, b}, {8'h0, exp});
    endtask

    initial begin
        tablero  = '0;
        i_actual = 3'd0;
        j_actual = 3'd0;
        state    = 4'd0;

        // reset hold
        repeat (10) @(posedge clk);
        #1;
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_blank", 32'(blank_n), 32'd0);
        chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
        chk("rst_vgaclk", 32'(vga_clk), 32'd0);
        chk("sync_n", 32'(sync_n), 32'd0);

        // first hsync fall after release: 4 clk latency + 2*656 clk to reach hc=656
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (hsync !== 1'b0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_hsync_window", 32'(n >= 1315 && n <= 1321), 32'd1);

        // hsync low width and line period
        m = 0;
        while (hsync === 1'b0 && m < 5000) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("hsync_low", 32'(m), 32'd192);
        while (hsync !== 1'b0 && m < 5000) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("line_period", 32'(m), 32'd1600);

        // blank_n high width on a visible line
        n = 0;
        while (blank_n !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        m = 0;
        while (blank_n === 1'b1 && m < 5000) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("blank_high", 32'(m), 32'd1280);

        // vsync low width and frame period
        n = 0;
        while (vsync !== 1'b0 && n < 900000) begin
            @(posedge clk);
            #1;
            n++;
        end
        m = 0;
        while (vsync === 1'b0 && m < 900000) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("vsync_low", 32'(m), 32'd3200);
        while (vsync !== 1'b0 && m < 900000) begin
            @(posedge clk);
            #1;
            m++;
        end
        chk("frame_period", 32'(m), 32'd840000);

        // mid-frame reset, board setup
        @(negedge clk);
        rst = 1'b0;
        tablero[1][2] = 7'b1000011;
        tablero[7][7] = 7'b0110000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2_blank", 32'(blank_n), 32'd0);
        chk("rst2_sync", {30'h0, hsync, vsync}, 32'd3);
        release_reset();
        chk("px_0_0", {8'h0, r, g, b}, 32'h0);

        chk_px("left_black", 20, 30, 24'h000000);
        chk_px("grid_v", 80, 30, 24'h404040);
        chk_px("cursor00", 82, 30, 24'hFFFF00);
        chk_px("unrevealed", 110, 30, 24'h808080);
        chk("vis_blank", {30'h0, blank_n, hsync}, 32'd3);
        state = 4'd6;
        chk_px("win_bg", 10, 31, 24'h008000);
        state    = 4'd0;
        i_actual = 3'd3;
        j_actual = 3'd3;
        chk_px("cursor_gone00", 82, 32, 24'h808080);
        chk_px("grid_h", 110, 60, 24'h404040);
        chk_px("rev_edge", 210, 70, 24'hC0C0C0);
        chk_px("rev_count3", 230, 90, 24'hFF0000);
        chk_px("cursor33", 262, 200, 24'hFFFF00);
        chk_px("flag_edge", 505, 450, 24'h808080);
        chk_px("flag_centre", 530, 450, 24'hFF0000);
        state = 4'd7;
        chk_px("lose_edge", 505, 451, 24'hFF0000);
        chk_px("lose_centre", 530, 451, 24'h000000);
        chk_px("porch_black", 700, 451, 24'h000000);
        chk("porch_blank", 32'(blank_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
